// File: rtl/fm_arbiter_if.sv
// Handshake bundle between the conv/pool masters and the feature-map arbiter.
// Index 0 is the conv master, index 1 is the pool master.
interface fm_arbiter_if #(
  parameter int COORD_BITS = 8,
  parameter int DW         = 32
);
  logic [1:0][COORD_BITS-1:0] rd_coord_x;
  logic [1:0][COORD_BITS-1:0] rd_coord_y;
  logic [1:0]                 rd_req;
  logic [1:0]                 rd_ready;
  logic [1:0][DW-1:0]         rd_data;

  logic [1:0][COORD_BITS-1:0] wr_coord_x;
  logic [1:0][COORD_BITS-1:0] wr_coord_y;
  logic [1:0][DW-1:0]         wr_data;
  logic [1:0]                 wr_req;
  logic [1:0]                 wr_ready;

  modport master (
    output rd_coord_x, rd_coord_y, rd_req,
    output wr_coord_x, wr_coord_y, wr_data, wr_req,
    input  rd_ready, rd_data, wr_ready
  );

  modport slave (
    input  rd_coord_x, rd_coord_y, rd_req,
    input  wr_coord_x, wr_coord_y, wr_data, wr_req,
    output rd_ready, rd_data, wr_ready
  );
endinterface

// File: rtl/fm_arbiter.sv
// Feature-map memory arbiter: one simple dual-port FM_W x FM_H memory shared by
// the conv and pool masters, with independent round-robin read and write
// arbitration, 2-cycle read latency and a one-address-per-cycle clear sweep.
module fm_arbiter #(
  parameter int COORD_BITS       = 8,
  parameter int CHANNELS         = 4,
  parameter int BITS_PER_CHANNEL = 8,
  parameter int FM_W             = 32,
  parameter int FM_H             = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  fm_arbiter_if.slave bus,
  input  logic        clear_start,
  output logic        clear_busy,
  output logic        clear_done,
  output logic        coord_err
);
  localparam int DW        = CHANNELS * BITS_PER_CHANNEL;
  localparam int DEPTH     = FM_W * FM_H;
  localparam int ADDR_BITS = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t               state_q, state_d;
  logic [ADDR_BITS-1:0] clr_cnt_q, clr_cnt_d;
  logic                 clr_done_q, clr_done_d;
  logic                 rr_rd_q, rr_wr_q;
  logic                 coord_err_q;

  logic                 rd_go, wr_go;
  logic                 rd_sel, wr_sel;
  logic                 rd_ok, wr_ok;
  logic [ADDR_BITS-1:0] rd_addr, wr_addr;
  logic [DW-1:0]        wr_wdata;

  logic [DW-1:0]        mem [DEPTH];

  logic                 rd_vld_p0;
  logic                 rd_idx_p0;
  logic                 rd_oor_p0;
  logic [DW-1:0]        rd_mem_p0;
  logic [1:0][DW-1:0]   rd_data_q;

  // Round-robin pick: a lone requester wins; on a tie the master that did not
  // win last time is chosen.
  function automatic logic arb_pick(input logic [1:0] req, input logic rr);
    if (req == 2'b11) return ~rr;
    return req[1];
  endfunction

  function automatic logic in_range(input logic [COORD_BITS-1:0] x,
                                    input logic [COORD_BITS-1:0] y);
    return (int'(x) < FM_W) && (int'(y) < FM_H);
  endfunction

  function automatic logic [ADDR_BITS-1:0] to_addr(input logic [COORD_BITS-1:0] x,
                                                   input logic [COORD_BITS-1:0] y);
    return ADDR_BITS'(int'(y) * FM_W + int'(x));
  endfunction

  // Next-state, grants and ready outputs; no grants while the sweep owns memory.
  always_comb begin
    state_d       = state_q;
    clr_cnt_d     = clr_cnt_q;
    clr_done_d    = 1'b0;
    rd_go         = 1'b0;
    wr_go         = 1'b0;
    bus.rd_ready  = 2'b00;
    bus.wr_ready  = 2'b00;
    rd_sel        = arb_pick(bus.rd_req, rr_rd_q);
    wr_sel        = arb_pick(bus.wr_req, rr_wr_q);
    rd_ok         = in_range(bus.rd_coord_x[rd_sel], bus.rd_coord_y[rd_sel]);
    wr_ok         = in_range(bus.wr_coord_x[wr_sel], bus.wr_coord_y[wr_sel]);
    rd_addr       = to_addr(bus.rd_coord_x[rd_sel], bus.rd_coord_y[rd_sel]);
    wr_addr       = to_addr(bus.wr_coord_x[wr_sel], bus.wr_coord_y[wr_sel]);
    wr_wdata      = bus.wr_data[wr_sel];
    case (state_q)
      IDLE: begin
        rd_go = |bus.rd_req;
        wr_go = |bus.wr_req;
        if (rd_go) bus.rd_ready[rd_sel] = 1'b1;
        if (wr_go) bus.wr_ready[wr_sel] = 1'b1;
        if (clear_start) begin
          state_d   = CLEAR;
          clr_cnt_d = '0;
        end
      end
      CLEAR: begin
        if (clr_cnt_q == ADDR_BITS'(DEPTH - 1)) begin
          state_d    = IDLE;
          clr_done_d = 1'b1;
        end else begin
          clr_cnt_d = clr_cnt_q + ADDR_BITS'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control state: FSM, sweep counter, round-robin pointers, status pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      clr_cnt_q   <= '0;
      clr_done_q  <= 1'b0;
      rr_rd_q     <= 1'b0;
      rr_wr_q     <= 1'b0;
      rd_vld_p0   <= 1'b0;
      coord_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      clr_cnt_q   <= clr_cnt_d;
      clr_done_q  <= clr_done_d;
      if (rd_go) rr_rd_q <= rd_sel;
      if (wr_go) rr_wr_q <= wr_sel;
      rd_vld_p0   <= rd_go;
      coord_err_q <= (rd_go && !rd_ok) || (wr_go && !wr_ok);
    end
  end

  // Stage p0: synchronous memory read; a same-cycle write to the same entry
  // forwards its data so the reader sees the new value.
  always_ff @(posedge clk) begin
    rd_idx_p0 <= rd_sel;
    rd_oor_p0 <= !rd_ok;
    if (rd_go && rd_ok)
      rd_mem_p0 <= (wr_go && wr_ok && (wr_addr == rd_addr)) ? wr_wdata : mem[rd_addr];
  end

  // Memory write port, shared between the clear sweep and granted writes.
  always_ff @(posedge clk) begin
    if (state_q == CLEAR)
      mem[clr_cnt_q] <= '0;
    else if (wr_go && wr_ok)
      mem[wr_addr] <= wr_wdata;
  end

  // Stage p1: per-master read-data holding registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      rd_data_q <= '0;
    else if (rd_vld_p0)
      rd_data_q[rd_idx_p0] <= rd_oor_p0 ? '0 : rd_mem_p0;
  end

  assign bus.rd_data = rd_data_q;
  assign clear_busy  = (state_q == CLEAR);
  assign clear_done  = clr_done_q;
  assign coord_err   = coord_err_q;
endmodule
